// File: rtl/blink_sequencer.sv
// blink_sequencer: steps a latched 16-entry on/off table onto a registered
// enable, one step every DIV clock cycles.
//
// Optional feature: define BLINK_SEQ_LOOP_EN to repeat the table until stop
// or RST instead of finishing with a one-cycle done pulse.
//
// state  | meaning
// IDLE   | waiting for start, all outputs low
// RUN    | sequence in progress, busy high, prescaler counting
// DONE   | one-cycle completion pulse, then back to IDLE

module blink_sequencer #(
   parameter int unsigned DIV = 25000000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic        stop,
   input  logic [15:0] pattern,
   input  logic [3:0]  len,
   output logic        state_l,
   output logic        busy,
   output logic [3:0]  step,
   output logic        done
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [15:0]   pattern_q;
   logic [3:0]    len_q;
   logic          tick;

   // End of the current step: last prescaler count while running.
   assign tick = (state == S_RUN) && (cnt == CNT_LAST);

   // Sequencer FSM, prescaler and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_IDLE;
         cnt       <= '0;
         pattern_q <= '0;
         len_q     <= '0;
         state_l   <= 1'b0;
         busy      <= 1'b0;
         step      <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (start) begin
                  pattern_q <= pattern;
                  len_q     <= len;
                  state     <= S_RUN;
                  busy      <= 1'b1;
                  step      <= '0;
                  state_l   <= pattern[0];
               end
            end
            S_RUN: begin
               if (stop) begin
                  // Abort wins over a coincident tick; no completion pulse.
                  state   <= S_IDLE;
                  cnt     <= '0;
                  busy    <= 1'b0;
                  step    <= '0;
                  state_l <= 1'b0;
               end else if (tick) begin
                  cnt <= '0;
                  if (step != len_q) begin
                     step    <= step + 4'd1;
                     state_l <= pattern_q[step + 4'd1];
                  end else begin
`ifdef BLINK_SEQ_LOOP_EN
                     step    <= '0;
                     state_l <= pattern_q[0];
`else
                     state   <= S_DONE;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     step    <= '0;
                     state_l <= 1'b0;
`endif
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
            default: begin
               state   <= S_IDLE;
               cnt     <= '0;
               busy    <= 1'b0;
               step    <= '0;
               state_l <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_blink_sequencer.sv
// Bench for blink_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a timeline model of the sequence.
// Honours BLINK_SEQ_LOOP_EN the same way the design does.

module tb_blink_sequencer;

   localparam int DIV = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic        start;
   logic        stop;
   logic [15:0] pattern;
   logic [3:0]  len;
   logic        state_l;
   logic        busy;
   logic [3:0]  step;
   logic        done;

   int checks = 0;
   int errors = 0;

   // Model: a running sequence is described by the edge it started on, the
   // latched table and the last step index; outputs follow from elapsed time.
   int          k = 0;
   bit          m_run = 1'b0;
   bit          m_done = 1'b0;
   int          m_k0 = 0;
   logic [15:0] m_pat = '0;
   logic [3:0]  m_len = '0;

   blink_sequencer #(.DIV(DIV)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .start   (start),
      .stop    (stop),
      .pattern (pattern),
      .len     (len),
      .state_l (state_l),
      .busy    (busy),
      .step    (step),
      .done    (done)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, k);
      end
   endtask

   // Apply one cycle of inputs, advance the model across the edge, then
   // compare all outputs mid-cycle.
   task automatic cyc(input logic r, input logic s, input logic sp,
                      input logic [15:0] p, input logic [3:0] l);
      bit prev_done;
      int idx;
      logic       e_state_l;
      logic       e_busy;
      logic [3:0] e_step;
      RST = r; start = s; stop = sp; pattern = p; len = l;
      @(posedge CLK);
      k++;
      prev_done = m_done;
      m_done = 1'b0;
      if (r) begin
         m_run = 1'b0;
      end else if (m_run) begin
         if (sp) m_run = 1'b0;
`ifndef BLINK_SEQ_LOOP_EN
         else if (k - m_k0 == (int'(m_len) + 1) * DIV) begin
            m_run  = 1'b0;
            m_done = 1'b1;
         end
`endif
      end else if (!prev_done && s) begin
         m_run = 1'b1;
         m_k0  = k;
         m_pat = p;
         m_len = l;
      end
      e_state_l = 1'b0;
      e_busy    = 1'b0;
      e_step    = '0;
      if (m_run) begin
         idx = (k - m_k0) / DIV;
`ifdef BLINK_SEQ_LOOP_EN
         idx = idx % (int'(m_len) + 1);
`endif
         e_state_l = m_pat[idx];
         e_busy    = 1'b1;
         e_step    = 4'(idx);
      end
      @(negedge CLK);
      chk("state_l", 16'(state_l), 16'(e_state_l));
      chk("busy",    16'(busy),    16'(e_busy));
      chk("step",    16'(step),    16'(e_step));
      chk("done",    16'(done),    16'(m_done));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'($urandom), 4'($urandom));
   endtask

   initial begin
      int dcyc;
      RST = 1'b1; start = 1'b0; stop = 1'b0; pattern = '0; len = '0;
      @(negedge CLK);

      // Reset state
      cyc(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
      cyc(1'b1, 1'b1, 1'b1, 16'hFFFF, 4'hF);
      idle(3);

      // Single-shot 1,0,1 and completion latency
      cyc(1'b0, 1'b1, 1'b0, 16'h0005, 4'd2);
      dcyc = -1;
      for (int i = 1; i <= 16; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 16'($urandom), 4'($urandom));
         if (done === 1'b1 && dcyc < 0) dcyc = i;
      end
`ifndef BLINK_SEQ_LOOP_EN
      chk("done_latency", 16'(dcyc), 16'(3 * DIV));
`else
      chk("loop_no_done", 16'(dcyc), 16'hFFFF);
      cyc(1'b0, 1'b0, 1'b1, 16'h0, 4'h0);
`endif
      idle(2);

      // Stop mid-run
      cyc(1'b0, 1'b1, 1'b0, 16'hFFFF, 4'd15);
      idle(5);
      cyc(1'b0, 1'b0, 1'b1, 16'h0, 4'h0);
      chk("stop_step", 16'(step), 16'h0);
      idle(4);

      // Start while busy is ignored
      cyc(1'b0, 1'b1, 1'b0, 16'h0001, 4'd1);
      idle(1);
      cyc(1'b0, 1'b1, 1'b0, 16'h0002, 4'd1);
      idle(10);
      cyc(1'b0, 1'b0, 1'b1, 16'h0, 4'h0);
      idle(2);

      // Stop coinciding with a tick: no advance, straight to idle
      cyc(1'b0, 1'b1, 1'b0, 16'h000A, 4'd3);
      idle(DIV - 1);
      cyc(1'b0, 1'b0, 1'b1, 16'h0, 4'h0);
      chk("stop_tick_busy", 16'(busy), 16'h0);
      idle(2);

      // Reset during run with start held high
      cyc(1'b0, 1'b1, 1'b0, 16'h00FF, 4'd7);
      idle(5);
      cyc(1'b1, 1'b1, 1'b0, 16'hFFFF, 4'd5);
      chk("rst_state_l", 16'(state_l), 16'h0);
      cyc(1'b0, 1'b1, 1'b0, 16'h0003, 4'd0);
      idle(DIV + 3);

      // len = 0 single step
      cyc(1'b0, 1'b0, 1'b1, 16'h0, 4'h0);
      idle(2);
      cyc(1'b0, 1'b1, 1'b0, 16'h0001, 4'd0);
      idle(DIV + 3);
      cyc(1'b0, 1'b0, 1'b1, 16'h0, 4'h0);

      // Start and stop together in idle: start wins
      cyc(1'b0, 1'b1, 1'b1, 16'h0006, 4'd2);
      idle(3 * DIV + 3);
      cyc(1'b0, 1'b0, 1'b1, 16'h0, 4'h0);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         cyc($urandom_range(0, 199) == 0,
             $urandom_range(0, 9) == 0,
             $urandom_range(0, 39) == 0,
             16'($urandom),
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
